_32_bit_seq_shift_left: RTL and testbench
=========================================

# _32_bit_seq_shift_left

Multi-cycle 32-bit logical shift-left unit, the left-direction counterpart to the ALU's arithmetic shift-right path. It accepts an operand and a shift amount through a start/done handshake. It applies the shift as five registered power-of-two stages, one stage per clock, and holds the result until the next operation. It sits beside the combinational ALU slices as the shared SLL resource for the multi-cycle datapath, with a smaller area than a full barrel shifter.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `LOG2W`, 5, number of shift stages; equal to log2(`WIDTH`).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  operand to shift.
- `b`  in  32  shift amount; `b[4:0]` is the distance, `b[31:5]` is the out-of-range detect.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse when `out` becomes valid.
- `out`  out  32  result; held until the next accepted start.
- `ovf`  out  1  a set bit was shifted out. Present only with `SHL_OVF_FLAG_EN`.

## Operation
- States:
  - IDLE: wait for `start`.
  - SHIFT: stage counter `cnt` runs 0..4.
  - DONE: result is written to `out`.
- IDLE, `start=1` → SHIFT. In the same edge:
  - `acc` ← `a`
  - `amt` ← `b[4:0]`
  - `big` ← OR of `b[31:5]`
  - `cnt` ← 0
  - `ovf` accumulator cleared
- SHIFT, each edge:
  - if `amt[cnt]` is 1, `acc` ← `acc << 2^cnt`, zero-filled; otherwise `acc` is unchanged.
  - `cnt` increments.
  - at `cnt==4` the next state is DONE.
- DONE, single edge:
  - `out` ← 0 if `big` is set, else `acc`.
  - `done` is 1 for this cycle only.
  - next state is IDLE.
- `start` outside IDLE is ignored: operands are not resampled and the current operation is not disturbed.
- `b[4:0]=0` with `big=0` → `out` equals `a`; latency is unchanged (no early exit).
- `a` and `b` may change freely after the start-sampling edge.
- Reset, including mid-operation:
  - state → IDLE
  - `out` = 0, `done` = 0, `busy` = 0, `ovf` = 0
  - `acc`, `amt` and `cnt` are cleared
  - any in-flight operation is discarded.

## Timing
- E0 is the edge that samples `start=1` in IDLE.
- `busy` is high from E0 until E6.
- Stages 0..4 apply at edges E1..E5.
- At E6: `out` and `ovf` update, and `done` is high for the E6–E7 cycle.
- The earliest next accepted start is at E7 (`start` held high continuously → one operation every 7 cycles).
- `out` is stable between E6 and the DONE edge of the next operation.
- Reset values: `busy` 0, `done` 0, `out` 0x0000_0000, `ovf` 0.

## Configuration
- `SHL_OVF_FLAG_EN` defined:
  - `ovf` port exists.
  - At each active stage, `ovf` |= OR of the top 2^cnt bits of `acc`, taken before the shift.
  - In DONE, `ovf` is forced to 1 if `big` is set and `a` was nonzero; this needs a registered flag for `a!=0` captured at E0.
  - `ovf` updates together with `out`.
- Not defined:
  - no `ovf` port and no tracking logic.
  - all other behaviour and timing are identical.

## Structure
- Shared header `alu_defs.vh` holds:
  - `WIDTH`/`LOG2W` defaults
  - state encodings IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- One sub-module, `_32_bit_shl_step`: combinational.
  - inputs: `acc[31:0]`, `k[2:0]`, `en`
  - outputs: `acc << 2^k` when `en` is high (else `acc`), and `lost` = OR of the dropped bits
  - built from 2:1 muxes per bit, consistent with the gate-level ALU slices.
- The top level holds the FSM, the counter and the registers.

## Test plan
- `a`=0x0000_0001, `b`=4, `start` at E0 → `busy` high E0–E6; `out`=0x0000_0010 and `done` pulse at E6; `ovf`=0.
- `a`=0x8000_0001, `b`=31 → `out`=0x8000_0000; `ovf`=1 (bit 31 lost).
- `a`=0xFFFF_FFFF, `b`=0x0000_0020 → `out`=0x0000_0000; `ovf`=1. Repeat with `b`=0x8000_0003 → `out`=0.
- `a`=0x1234_5678, `b`=0 → `out`=0x1234_5678 at E6 (full latency); `ovf`=0.
- Op1 (`a`=0x1, `b`=8) started; at E3 assert `start` with `a`=0xF, `b`=1 → ignored; `out`=0x0000_0100 at E6. Re-issued at E7 → `out`=0x0000_001E at E13.
- Start op (`a`=0x3, `b`=2); assert `reset` at E3 → after E4 `busy`=0, `done`=0, `out`=0, and no `done` pulse follows. A new op (`a`=0x3, `b`=2) gives `out`=0x0000_000C.

Source files
------------

// File: rtl/_32_bit_seq_shift_left_pkg.sv
// Shared constants and FSM state encoding for the multi-cycle shift-left unit.
package _32_bit_seq_shift_left_pkg;

  localparam int WIDTH = 32;
  localparam int LOG2W = 5;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOG2W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/_32_bit_shl_step.sv
// One power-of-two shift-left stage: res = acc << 2^k when en, else acc;
// lost flags any set bit pushed out of the top.
module _32_bit_shl_step
  import _32_bit_seq_shift_left_pkg::*;
(
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       k,
  input  logic             en,
  output logic [WIDTH-1:0] res,
  output logic             lost
);

  logic [WIDTH-1:0] shifted;
  logic             dropped;

  always_comb begin
    shifted = '0;
    dropped = 1'b0;
    case (k)
      3'd0: begin shifted = acc << 1;  dropped = |acc[WIDTH-1 -: 1];  end
      3'd1: begin shifted = acc << 2;  dropped = |acc[WIDTH-1 -: 2];  end
      3'd2: begin shifted = acc << 4;  dropped = |acc[WIDTH-1 -: 4];  end
      3'd3: begin shifted = acc << 8;  dropped = |acc[WIDTH-1 -: 8];  end
      3'd4: begin shifted = acc << 16; dropped = |acc[WIDTH-1 -: 16]; end
      default: begin shifted = '0; dropped = |acc; end
    endcase
  end

  // Per-bit 2:1 mux between the untouched and the shifted word.
  assign res  = en ? shifted : acc;
  assign lost = en & dropped;

endmodule

// File: rtl/_32_bit_seq_shift_left.sv
// Multi-cycle 32-bit logical shift-left: start/done handshake, five registered
// power-of-two stages. Optional overflow flag enabled by SHL_OVF_FLAG_EN.
module _32_bit_seq_shift_left
  import _32_bit_seq_shift_left_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef SHL_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LOG2W-1:0] amt_q, amt_d;
  logic             big_q, big_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;

  logic             step_en;
  logic [WIDTH-1:0] step_res;
  logic             step_lost;

  _32_bit_shl_step u_step (
    .acc  (acc_q),
    .k    (cnt_q),
    .en   (step_en),
    .res  (step_res),
    .lost (step_lost)
  );

`ifdef SHL_OVF_FLAG_EN
  logic ovf_acc_q, ovf_acc_d;
  logic a_nz_q, a_nz_d;
  logic ovf_q, ovf_d;
`else
  logic lost_unused;
  assign lost_unused = step_lost;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    big_d   = big_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    step_en = 1'b0;
`ifdef SHL_OVF_FLAG_EN
    ovf_acc_d = ovf_acc_q;
    a_nz_d    = a_nz_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          acc_d   = a;
          amt_d   = b[LOG2W-1:0];
          big_d   = |b[WIDTH-1:LOG2W];
          cnt_d   = '0;
`ifdef SHL_OVF_FLAG_EN
          ovf_acc_d = 1'b0;
          a_nz_d    = |a;
`endif
        end
      end
      ST_SHIFT: begin
        step_en = amt_q[cnt_q];
        acc_d   = step_res;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
`ifdef SHL_OVF_FLAG_EN
        ovf_acc_d = ovf_acc_q | step_lost;
`endif
      end
      ST_DONE: begin
        // An out-of-range distance clears the whole word regardless of acc.
        out_d   = big_q ? '0 : acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef SHL_OVF_FLAG_EN
        ovf_d = ovf_acc_q | (big_q & a_nz_q);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, so an aborted operation leaves no residue.
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      big_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef SHL_OVF_FLAG_EN
      ovf_acc_q <= 1'b0;
      a_nz_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      big_q   <= big_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef SHL_OVF_FLAG_EN
      ovf_acc_q <= ovf_acc_d;
      a_nz_q    <= a_nz_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign out  = out_q;
`ifdef SHL_OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb__32_bit_seq_shift_left.sv
// Self-checking bench for _32_bit_seq_shift_left: directed vector table,
// handshake corner sequences, and randomized ops against an arithmetic model.
module tb__32_bit_seq_shift_left;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] dout;
`ifdef SHL_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  _32_bit_seq_shift_left dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (dout)
`ifdef SHL_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef SHL_OVF_FLAG_EN
    check(name, {31'b0, ovf}, {31'b0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  // Reference: a * 2^b truncated to 32 bits; anything at or beyond 32 is zero.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                output logic [31:0] o, output logic v);
    logic [63:0] wide;
    if (ib > 32'd31) begin
      o = 32'd0;
      v = (ia != 32'd0);
    end else begin
      wide = {32'd0, ia} << ib;
      o = wide[31:0];
      v = (wide[63:32] != 32'd0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with cycle-exact handshake checks from E0 to E7.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eo, input logic ev, input string name);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    check({name, " busy@E0"}, {31'b0, busy}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) begin
        check({name, " busy@E5"}, {31'b0, busy}, 32'd1);
        check({name, " done@E5"}, {31'b0, done}, 32'd0);
      end
    end
    tick();
    check({name, " done@E6"}, {31'b0, done}, 32'd1);
    check({name, " busy@E6"}, {31'b0, busy}, 32'd0);
    check({name, " out@E6"}, dout, eo);
    check_ovf({name, " ovf@E6"}, ev);
    tick();
    check({name, " done@E7"}, {31'b0, done}, 32'd0);
    check({name, " out@E7"}, dout, eo);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] eo, ra, rb;
    logic        ev;
    bit          saw_done;

    vecs[0] = '{32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0};
    vecs[1] = '{32'h8000_0001, 32'd31,         32'h8000_0000, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0020,  32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0003,  32'h0000_0000, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'd0,          32'h1234_5678, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0040,  32'h0000_0000, 1'b0};
    vecs[6] = '{32'h0000_0001, 32'd31,         32'h8000_0000, 1'b0};
    vecs[7] = '{32'hF000_000F, 32'd4,          32'h0000_00F0, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset out", dout, 32'd0);
    check_ovf("reset ovf", 1'b0);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_ovf,
                            $sformatf("vec%0d", i));

    // Start during SHIFT/DONE is ignored; held start is accepted at E7.
    @(negedge clk);
    start = 1'b1; a = 32'h1; b = 32'd8;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 32'hF; b = 32'd1;
    for (int i = 3; i <= 5; i++) tick();
    check("ign busy@E5", {31'b0, busy}, 32'd1);
    tick();
    check("ign done@E6", {31'b0, done}, 32'd1);
    check("ign out@E6", dout, 32'h0000_0100);
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    check("reissue busy@E7", {31'b0, busy}, 32'd1);
    check("reissue done@E7", {31'b0, done}, 32'd0);
    for (int i = 8; i <= 12; i++) tick();
    check("reissue hold@E12", dout, 32'h0000_0100);
    check("reissue done@E12", {31'b0, done}, 32'd0);
    tick();
    check("reissue done@E13", {31'b0, done}, 32'd1);
    check("reissue out@E13", dout, 32'h0000_001E);
    tick();

    // Reset mid-operation discards the op and clears outputs.
    @(negedge clk);
    start = 1'b1; a = 32'h3; b = 32'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst out", dout, 32'd0);
    check_ovf("midrst ovf", 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("midrst no done", {31'b0, saw_done}, 32'd0);
    do_op(32'h3, 32'd2, 32'h0000_000C, 1'b0, "after rst");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'd1 << $urandom_range(5, 31);
        default: rb = $urandom_range(0, 31);
      endcase
      if (n % 7 == 0) ra = 32'd1 << $urandom_range(0, 31);
      model(ra, rb, eo, ev);
      do_op(ra, rb, eo, ev, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
